alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Registered, parametrised ALU control unit with valid/ready handshake and a multi-cycle MDU sequencer.
//  Decodes ALUop/func into alu_operation and jr, one output register stage.
//  Issues MULT/DIV to an external iterative mul/div unit (MDU) and waits for completion with a timeout.
//  Sits between the main control decoder and the ALU/MDU in the execute stage.
// PARAMETERS
//  OP_W         4   alu_operation width, >=4; codes below are zero-extended into upper bits
//  MDU_TIMEOUT  64  cycles allowed in MDU_WAIT before abort; >=2
//  ENABLE_MDU   1   0: MULT/DIV decode as illegal, mdu_start never asserts
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush          in   1     synchronous pipeline flush
//  in_valid       in   1     func/ALUop valid
//  in_ready       out  1     unit can accept this cycle
//  func           in   6     R-type function field
//  ALUop          in   2     00 add, 01 sub, 11 and, 10 decode func
//  out_valid      out  1     registered outputs valid
//  out_ready      in   1     downstream consumes output
//  alu_operation  out  OP_W  ALU operation code
//  jr             out  1     jump-register instruction
//  illegal        out  1     unsupported func or MDU timeout
//  mdu_start      out  1     1-cycle pulse launching MDU
//  mdu_op         out  1     0 MULT, 1 DIV; held while busy
//  mdu_done       in   1     MDU completion pulse
//  mdu_abort      out  1     1-cycle pulse: MDU op cancelled (flush or timeout)
//  busy           out  1     high in MDU_WAIT
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE; all outputs 0, counter 0.
//  Decode: ALUop 00->0010, 01->0110, 11->0000 (AND), 10->func: 100000 add 0010, 100010 sub 0110,
//   100100 and 0000, 100101 or 0001, 100111 nor 1100, 101010 slt 0111, 000000 sll 0011,
//   000010 srl 0100, 001000 jr (op 0010, jr=1), 011000 MULT, 011010 DIV; other -> op 0010, illegal=1.
//  FSM IDLE / HOLD / MDU_WAIT. in_ready = !flush & (IDLE | (HOLD & out_ready)).
//  Accept (in_valid & in_ready): non-MDU -> HOLD, outputs loaded next edge (latency 1), out_valid=1.
//   MDU -> MDU_WAIT, mdu_start=1 for exactly that next cycle, mdu_op set, out_valid=0, counter=0.
//  HOLD: outputs stable while out_valid & !out_ready. out_ready & no accept -> IDLE, out_valid=0.
//   out_ready & accept -> back-to-back load, throughput 1/cycle.
//  MDU_WAIT: counter +1 per cycle; mdu_done -> HOLD, op 1000 (MDU result pass), illegal=0.
//   counter==MDU_TIMEOUT-1 without done -> HOLD, op 1000, illegal=1, mdu_abort pulse.
//   done and timeout same cycle: done wins, no abort. mdu_done outside MDU_WAIT ignored.
//  flush: highest priority; next state IDLE, out_valid/jr/illegal/busy=0, counter 0;
//   flush in MDU_WAIT also pulses mdu_abort. Flush with in_valid: input not accepted.
//  jr, illegal only meaningful while out_valid=1; both 0 whenever out_valid=0.
// TESTING
//  Reset mid MDU_WAIT: rst_n low -> busy=0, out_valid=0, no mdu_abort pulse, async (before next edge).
//  Stream ALUop=10 func 100000,100111,101010 with out_ready=1 -> ops 0010,1100,0111 on 3 consecutive cycles.
//  func=001000 with out_ready=0 for 3 cycles -> out_valid=1, jr=1, op 0010 held; in_ready=0 throughout.
//  func=011010, mdu_done after 5 cycles -> mdu_start 1 pulse, mdu_op=1, busy 5 cycles, then op 1000, illegal=0.
//  MULT, no mdu_done, MDU_TIMEOUT=64 -> abort pulse after 64 busy cycles, out_valid=1, illegal=1.
//  func=111111 -> illegal=1, op 0010; flush asserted same cycle as MDU accept -> no mdu_start, IDLE.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// ALU control decode with one registered output stage (latency 1, stalls while out_valid & !out_ready),
// plus a MULT/DIV launcher that waits in MDU_WAIT for mdu_done or aborts after MDU_TIMEOUT cycles.
module alu_ctrl_seq #(
  parameter int OP_W        = 4,
  parameter int MDU_TIMEOUT = 64,
  parameter bit ENABLE_MDU  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      func,
  input  logic [1:0]      ALUop,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] alu_operation,
  output logic            jr,
  output logic            illegal,
  output logic            mdu_start,
  output logic            mdu_op,
  input  logic            mdu_done,
  output logic            mdu_abort,
  output logic            busy
);

  localparam int CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [3:0] OP_MDU = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MDU_WAIT} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q, jr_q, illegal_q, mdu_start_q, mdu_op_q, mdu_abort_q;
  logic [OP_W-1:0]   op_q;

  logic [3:0] op_d;
  logic       jr_d, illegal_d, is_mdu_d, mdu_op_d;
  logic       accept;

  always_comb begin
    op_d      = 4'b0010;
    jr_d      = 1'b0;
    illegal_d = 1'b0;
    is_mdu_d  = 1'b0;
    mdu_op_d  = 1'b0;
    unique case (ALUop)
      2'b00: op_d = 4'b0010;
      2'b01: op_d = 4'b0110;
      2'b11: op_d = 4'b0000;
      default: begin
        unique case (func)
          6'b100000: op_d = 4'b0010;
          6'b100010: op_d = 4'b0110;
          6'b100100: op_d = 4'b0000;
          6'b100101: op_d = 4'b0001;
          6'b100111: op_d = 4'b1100;
          6'b101010: op_d = 4'b0111;
          6'b000000: op_d = 4'b0011;
          6'b000010: op_d = 4'b0100;
          6'b001000: jr_d = 1'b1;
          6'b011000, 6'b011010: begin
            // With the MDU compiled out these fall through as unsupported.
            if (ENABLE_MDU) begin
              is_mdu_d = 1'b1;
              mdu_op_d = func[1];
            end else begin
              illegal_d = 1'b1;
            end
          end
          default: illegal_d = 1'b1;
        endcase
      end
    endcase
  end

  assign in_ready = !flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      jr_q        <= 1'b0;
      illegal_q   <= 1'b0;
      mdu_start_q <= 1'b0;
      mdu_op_q    <= 1'b0;
      mdu_abort_q <= 1'b0;
    end else begin
      mdu_start_q <= 1'b0;
      mdu_abort_q <= 1'b0;
      if (flush) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        out_valid_q <= 1'b0;
        jr_q        <= 1'b0;
        illegal_q   <= 1'b0;
        mdu_abort_q <= (state_q == S_MDU_WAIT);
      end else if (accept) begin
        cnt_q <= '0;
        if (is_mdu_d) begin
          state_q     <= S_MDU_WAIT;
          out_valid_q <= 1'b0;
          jr_q        <= 1'b0;
          illegal_q   <= 1'b0;
          mdu_start_q <= 1'b1;
          mdu_op_q    <= mdu_op_d;
        end else begin
          state_q     <= S_HOLD;
          out_valid_q <= 1'b1;
          op_q        <= OP_W'(op_d);
          jr_q        <= jr_d;
          illegal_q   <= illegal_d;
        end
      end else begin
        unique case (state_q)
          S_HOLD: begin
            if (out_ready) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              jr_q        <= 1'b0;
              illegal_q   <= 1'b0;
            end
          end
          S_MDU_WAIT: begin
            // Completion takes precedence over a timeout landing on the same cycle.
            if (mdu_done || (cnt_q == CNT_LAST)) begin
              state_q     <= S_HOLD;
              out_valid_q <= 1'b1;
              op_q        <= OP_W'(OP_MDU);
              jr_q        <= 1'b0;
              illegal_q   <= !mdu_done;
              mdu_abort_q <= !mdu_done;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_operation = op_q;
  assign jr            = jr_q;
  assign illegal       = illegal_q;
  assign mdu_start     = mdu_start_q;
  assign mdu_op        = mdu_op_q;
  assign mdu_abort     = mdu_abort_q;
  assign busy          = (state_q == S_MDU_WAIT);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode stream, stall hold, MDU done/timeout, flush and async reset.
module tb_alu_ctrl_seq;
  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready, mdu_done;
  logic [5:0] func;
  logic [1:0] ALUop;
  logic       in_ready, out_valid, jr, illegal, mdu_start, mdu_op, mdu_abort, busy;
  logic [3:0] alu_operation;
  int         checks = 0;
  int         failures = 0;
  int         nbusy;

  alu_ctrl_seq #(.OP_W(4), .MDU_TIMEOUT(64), .ENABLE_MDU(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .alu_operation(alu_operation), .jr(jr), .illegal(illegal), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_done(mdu_done), .mdu_abort(mdu_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mdu_done = 1'b0;
    func = 6'd0; ALUop = 2'b00;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mdu_start", 32'(mdu_start), 32'd0);
    chk("rst_op", 32'(alu_operation), 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back decode stream
    in_valid = 1'b1; ALUop = 2'b10; out_ready = 1'b1; func = 6'b100000;
    tick(); chk("s1_op", 32'(alu_operation), 32'h2); chk("s1_vld", 32'(out_valid), 32'd1);
    chk("s1_in_ready", 32'(in_ready), 32'd1);
    func = 6'b100111;
    tick(); chk("s2_op", 32'(alu_operation), 32'hC); chk("s2_vld", 32'(out_valid), 32'd1);
    func = 6'b101010;
    tick(); chk("s3_op", 32'(alu_operation), 32'h7); chk("s3_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick(); chk("s_drain_vld", 32'(out_valid), 32'd0);

    // jr held under backpressure
    in_valid = 1'b1; func = 6'b001000; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("jr_vld", 32'(out_valid), 32'd1);
      chk("jr_jr", 32'(jr), 32'd1);
      chk("jr_op", 32'(alu_operation), 32'h2);
      chk("jr_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("jr_release_in_ready", 32'(in_ready), 32'd1);
    tick(); chk("jr_drain_vld", 32'(out_valid), 32'd0); chk("jr_drain_jr", 32'(jr), 32'd0);

    // DIV completing after 5 busy cycles
    in_valid = 1'b1; func = 6'b011010;
    tick();
    in_valid = 1'b0;
    chk("div_start", 32'(mdu_start), 32'd1); chk("div_op", 32'(mdu_op), 32'd1);
    chk("div_busy", 32'(busy), 32'd1); chk("div_vld", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("div_busy_n", 32'(busy), 32'd1); chk("div_start_low", 32'(mdu_start), 32'd0);
    end
    mdu_done = 1'b1;
    tick(); mdu_done = 1'b0;
    chk("div_done_busy", 32'(busy), 32'd0); chk("div_done_vld", 32'(out_valid), 32'd1);
    chk("div_done_op", 32'(alu_operation), 32'h8); chk("div_done_ill", 32'(illegal), 32'd0);
    chk("div_done_abort", 32'(mdu_abort), 32'd0);
    tick(); chk("div_drain_vld", 32'(out_valid), 32'd0);

    // Stray mdu_done in IDLE
    mdu_done = 1'b1;
    tick(); mdu_done = 1'b0;
    chk("stray_done_vld", 32'(out_valid), 32'd0); chk("stray_done_busy", 32'(busy), 32'd0);

    // MULT timeout
    in_valid = 1'b1; func = 6'b011000;
    tick();
    in_valid = 1'b0;
    chk("mul_start", 32'(mdu_start), 32'd1); chk("mul_op", 32'(mdu_op), 32'd0);
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
      if (busy) nbusy++;
    end
    chk("mul_busy_cycles", 32'(nbusy), 32'd64);
    chk("mul_abort", 32'(mdu_abort), 32'd1); chk("mul_vld", 32'(out_valid), 32'd1);
    chk("mul_ill", 32'(illegal), 32'd1); chk("mul_res_op", 32'(alu_operation), 32'h8);
    tick(); chk("mul_abort_pulse", 32'(mdu_abort), 32'd0); chk("mul_drain_vld", 32'(out_valid), 32'd0);

    // Illegal func, then ALUop shortcuts back-to-back
    in_valid = 1'b1; func = 6'b111111;
    tick(); chk("ill_ill", 32'(illegal), 32'd1); chk("ill_op", 32'(alu_operation), 32'h2);
    chk("ill_jr", 32'(jr), 32'd0);
    ALUop = 2'b11;
    tick(); chk("and_op", 32'(alu_operation), 32'h0); chk("and_ill", 32'(illegal), 32'd0);
    ALUop = 2'b01;
    tick(); chk("sub_op", 32'(alu_operation), 32'h6);
    in_valid = 1'b0;
    tick();

    // Flush coincident with an MDU request
    in_valid = 1'b1; ALUop = 2'b10; func = 6'b011000; flush = 1'b1; #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_start", 32'(mdu_start), 32'd0); chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_vld", 32'(out_valid), 32'd0);

    // Flush while waiting on the MDU
    in_valid = 1'b1; func = 6'b011010;
    tick(); in_valid = 1'b0;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    chk("fw_abort", 32'(mdu_abort), 32'd1); chk("fw_busy", 32'(busy), 32'd0);
    tick(); chk("fw_abort_pulse", 32'(mdu_abort), 32'd0);

    // Async reset mid MDU_WAIT
    in_valid = 1'b1; func = 6'b011000;
    tick(); in_valid = 1'b0;
    tick();
    chk("ar_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("ar_busy", 32'(busy), 32'd0); chk("ar_vld", 32'(out_valid), 32'd0);
    chk("ar_abort", 32'(mdu_abort), 32'd0); chk("ar_start", 32'(mdu_start), 32'd0);
    tick(); rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
